// File: rtl/ttt_pkg.sv
// Shared types, codes and win-line masks for the tic-tac-toe game controller.
package ttt_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_MOVE = 2'd1,
        CHECK     = 2'd2,
        DONE      = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        REJ_NONE     = 2'd0,
        REJ_TURN     = 2'd1,
        REJ_RANGE    = 2'd2,
        REJ_OCCUPIED = 2'd3
    } rej_e;

    typedef enum logic [1:0] {
        WIN_NONE = 2'd0,
        WIN_P1   = 2'd1,
        WIN_P2   = 2'd2,
        WIN_DRAW = 2'd3
    } winner_e;

    localparam int NUM_LINES = 8;
    localparam logic [3:0] MAX_POS = 4'd8;

    // Index 0..2 rows, 3..5 columns, 6 main diagonal, 7 anti-diagonal.
    localparam logic [NUM_LINES-1:0][8:0] WIN_LINES = {
        9'b001_010_100,
        9'b100_010_001,
        9'b100_100_100,
        9'b010_010_010,
        9'b001_001_001,
        9'b111_000_000,
        9'b000_111_000,
        9'b000_000_111
    };

    // One-hot cell mask for a position; out-of-range positions give all zeros.
    function automatic logic [8:0] pos_mask(input logic [3:0] pos);
        logic [8:0] m;
        m = '0;
        for (int i = 0; i < 9; i++) begin
            if (pos == 4'(i)) m[i] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/ttt_line_check.sv
// Combinational detector: flags every winning line fully covered by one player's marks.
module ttt_line_check
    import ttt_pkg::*;
(
    input  logic [8:0]           i_marks,
    output logic [NUM_LINES-1:0] o_lines
);

    always_comb begin
        o_lines = '0;
        for (int i = 0; i < NUM_LINES; i++) begin
            o_lines[i] = ((i_marks & WIN_LINES[i]) == WIN_LINES[i]);
        end
    end

endmodule

// File: rtl/ttt_game_ctrl.sv
// Tic-tac-toe turn sequencer, move arbiter and win/draw detector.
// Optional turn time limit is enabled by defining TTT_TURN_TIMEOUT_EN.
module ttt_game_ctrl
    import ttt_pkg::*;
#(
    parameter int N_CELLS = 9
`ifdef TTT_TURN_TIMEOUT_EN
    , parameter int TIMEOUT_CYCLES = 1000
`endif
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_new_game,
    input  logic               i_p1_req,
    input  logic [3:0]         i_p1_pos,
    input  logic               i_p2_req,
    input  logic [3:0]         i_p2_pos,
    output logic               o_p1_ack,
    output logic               o_p2_ack,
    output logic               o_rej_valid,
    output logic [1:0]         o_rej_code,
    output logic [N_CELLS-1:0] o_p1_marks,
    output logic [N_CELLS-1:0] o_p2_marks,
    output logic               o_turn,
    output logic               o_game_over,
    output logic [1:0]         o_winner,
    output logic [7:0]         o_win_line
`ifdef TTT_TURN_TIMEOUT_EN
    , output logic             o_timeout
`endif
);

    state_e             r_state, w_next_state;
    logic [N_CELLS-1:0] r_p1_marks, w_next_p1_marks;
    logic [N_CELLS-1:0] r_p2_marks, w_next_p2_marks;
    logic               r_turn, w_next_turn;
    logic               r_p1_ack, w_next_p1_ack;
    logic               r_p2_ack, w_next_p2_ack;
    logic               r_rej_valid, w_next_rej_valid;
    logic [1:0]         r_rej_code, w_next_rej_code;
    logic [1:0]         r_winner, w_next_winner;
    logic [7:0]         r_win_line, w_next_win_line;
`ifdef TTT_TURN_TIMEOUT_EN
    logic [31:0]        r_turn_cnt, w_next_turn_cnt;
    logic               r_timeout, w_next_timeout;
`endif

    logic               w_cand_req, w_off_req, w_accept;
    logic [3:0]         w_cand_pos;
    logic [8:0]         w_cand_cell;
    logic [1:0]         w_cand_code;
    logic [N_CELLS-1:0] w_mover_marks;
    logic [7:0]         w_lines;

    // The player whose turn it is is the only one who can be granted.
    assign w_cand_req    = r_turn ? i_p2_req : i_p1_req;
    assign w_off_req     = r_turn ? i_p1_req : i_p2_req;
    assign w_cand_pos    = r_turn ? i_p2_pos : i_p1_pos;
    assign w_cand_cell   = pos_mask(w_cand_pos);
    assign w_cand_code   = (w_cand_pos > MAX_POS)                         ? REJ_RANGE
                         : (|(w_cand_cell & (r_p1_marks | r_p2_marks)))   ? REJ_OCCUPIED
                         :                                                  REJ_NONE;
    assign w_accept      = (r_state == WAIT_MOVE) && w_cand_req && (w_cand_code == REJ_NONE);
    assign w_mover_marks = r_turn ? r_p2_marks : r_p1_marks;

    ttt_line_check u_line_check (
        .i_marks (w_mover_marks),
        .o_lines (w_lines)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_p1_marks  <= '0;
            r_p2_marks  <= '0;
            r_turn      <= 1'b0;
            r_p1_ack    <= 1'b0;
            r_p2_ack    <= 1'b0;
            r_rej_valid <= 1'b0;
            r_rej_code  <= REJ_NONE;
            r_winner    <= WIN_NONE;
            r_win_line  <= '0;
`ifdef TTT_TURN_TIMEOUT_EN
            r_turn_cnt  <= '0;
            r_timeout   <= 1'b0;
`endif
        end else begin
            r_state     <= w_next_state;
            r_p1_marks  <= w_next_p1_marks;
            r_p2_marks  <= w_next_p2_marks;
            r_turn      <= w_next_turn;
            r_p1_ack    <= w_next_p1_ack;
            r_p2_ack    <= w_next_p2_ack;
            r_rej_valid <= w_next_rej_valid;
            r_rej_code  <= w_next_rej_code;
            r_winner    <= w_next_winner;
            r_win_line  <= w_next_win_line;
`ifdef TTT_TURN_TIMEOUT_EN
            r_turn_cnt  <= w_next_turn_cnt;
            r_timeout   <= w_next_timeout;
`endif
        end
    end

    always_comb begin
        w_next_state     = r_state;
        w_next_p1_marks  = r_p1_marks;
        w_next_p2_marks  = r_p2_marks;
        w_next_turn      = r_turn;
        w_next_p1_ack    = 1'b0;
        w_next_p2_ack    = 1'b0;
        w_next_rej_valid = 1'b0;
        w_next_rej_code  = REJ_NONE;
        w_next_winner    = r_winner;
        w_next_win_line  = r_win_line;
`ifdef TTT_TURN_TIMEOUT_EN
        w_next_turn_cnt  = r_turn_cnt;
        w_next_timeout   = r_timeout;
`endif
        if (i_new_game) begin
            w_next_state    = WAIT_MOVE;
            w_next_p1_marks = '0;
            w_next_p2_marks = '0;
            w_next_turn     = 1'b0;
            w_next_winner   = WIN_NONE;
            w_next_win_line = '0;
`ifdef TTT_TURN_TIMEOUT_EN
            w_next_turn_cnt = '0;
            w_next_timeout  = 1'b0;
`endif
        end else begin
            case (r_state)
                WAIT_MOVE: begin
                    // An illegal on-turn request outranks an off-turn reject code.
                    if (w_cand_req && (w_cand_code != REJ_NONE)) begin
                        w_next_rej_valid = 1'b1;
                        w_next_rej_code  = w_cand_code;
                    end else if (w_off_req) begin
                        w_next_rej_valid = 1'b1;
                        w_next_rej_code  = REJ_TURN;
                    end
                    if (w_accept) begin
                        w_next_state = CHECK;
                        if (r_turn) begin
                            w_next_p2_marks = r_p2_marks | w_cand_cell;
                            w_next_p2_ack   = 1'b1;
                        end else begin
                            w_next_p1_marks = r_p1_marks | w_cand_cell;
                            w_next_p1_ack   = 1'b1;
                        end
                    end
`ifdef TTT_TURN_TIMEOUT_EN
                    w_next_turn_cnt = r_turn_cnt + 32'd1;
                    if (!w_accept && (w_next_turn_cnt == 32'(TIMEOUT_CYCLES))) begin
                        w_next_state    = DONE;
                        w_next_winner   = r_turn ? WIN_P1 : WIN_P2;
                        w_next_win_line = '0;
                        w_next_timeout  = 1'b1;
                    end
`endif
                end
                CHECK: begin
                    if (|w_lines) begin
                        w_next_state    = DONE;
                        w_next_winner   = r_turn ? WIN_P2 : WIN_P1;
                        w_next_win_line = w_lines;
                    end else if (&(r_p1_marks | r_p2_marks)) begin
                        w_next_state    = DONE;
                        w_next_winner   = WIN_DRAW;
                        w_next_win_line = '0;
                    end else begin
                        w_next_state    = WAIT_MOVE;
                        w_next_turn     = ~r_turn;
`ifdef TTT_TURN_TIMEOUT_EN
                        w_next_turn_cnt = '0;
`endif
                    end
                end
                IDLE, DONE: begin
                    w_next_state = r_state;
                end
                default: begin
                    w_next_state = IDLE;
                end
            endcase
        end
    end

    assign o_p1_ack    = r_p1_ack;
    assign o_p2_ack    = r_p2_ack;
    assign o_rej_valid = r_rej_valid;
    assign o_rej_code  = r_rej_code;
    assign o_p1_marks  = r_p1_marks;
    assign o_p2_marks  = r_p2_marks;
    assign o_turn      = r_turn;
    assign o_game_over = (r_state == DONE);
    assign o_winner    = r_winner;
    assign o_win_line  = r_win_line;
`ifdef TTT_TURN_TIMEOUT_EN
    assign o_timeout   = r_timeout;
`endif

endmodule

// File: tb/tb_ttt_game_ctrl.sv
// Directed, table-driven bench for ttt_game_ctrl with hand sequences for draw, async reset and timeout.
module tb_ttt_game_ctrl;

    typedef struct packed {
        logic       ng;
        logic       r1;
        logic [3:0] p1;
        logic       r2;
        logic [3:0] p2;
    } in_t;

    typedef struct packed {
        logic       ack1;
        logic       ack2;
        logic       rv;
        logic [1:0] rc;
        logic [8:0] m1;
        logic [8:0] m2;
        logic       turn;
        logic       go;
        logic [1:0] win;
        logic [7:0] wl;
    } out_t;

    typedef struct packed {
        in_t  stim;
        out_t exp;
    } vec_t;

    logic       clk;
    logic       reset;
    logic       i_new_game;
    logic       i_p1_req;
    logic [3:0] i_p1_pos;
    logic       i_p2_req;
    logic [3:0] i_p2_pos;
    logic       o_p1_ack;
    logic       o_p2_ack;
    logic       o_rej_valid;
    logic [1:0] o_rej_code;
    logic [8:0] o_p1_marks;
    logic [8:0] o_p2_marks;
    logic       o_turn;
    logic       o_game_over;
    logic [1:0] o_winner;
    logic [7:0] o_win_line;
`ifdef TTT_TURN_TIMEOUT_EN
    logic       o_timeout;
`endif

    int checks = 0;
    int errors = 0;
    vec_t vecs[$];

    ttt_game_ctrl #(
        .N_CELLS (9)
`ifdef TTT_TURN_TIMEOUT_EN
        , .TIMEOUT_CYCLES (20)
`endif
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .i_new_game  (i_new_game),
        .i_p1_req    (i_p1_req),
        .i_p1_pos    (i_p1_pos),
        .i_p2_req    (i_p2_req),
        .i_p2_pos    (i_p2_pos),
        .o_p1_ack    (o_p1_ack),
        .o_p2_ack    (o_p2_ack),
        .o_rej_valid (o_rej_valid),
        .o_rej_code  (o_rej_code),
        .o_p1_marks  (o_p1_marks),
        .o_p2_marks  (o_p2_marks),
        .o_turn      (o_turn),
        .o_game_over (o_game_over),
        .o_winner    (o_winner),
        .o_win_line  (o_win_line)
`ifdef TTT_TURN_TIMEOUT_EN
        , .o_timeout (o_timeout)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mkVec(input logic ng, input logic r1, input logic [3:0] p1,
                                   input logic r2, input logic [3:0] p2,
                                   input logic a1, input logic a2, input logic rv, input logic [1:0] rc,
                                   input logic [8:0] m1, input logic [8:0] m2,
                                   input logic t, input logic go, input logic [1:0] w, input logic [7:0] wl);
        vec_t v;
        v.stim = {ng, r1, p1, r2, p2};
        v.exp  = {a1, a2, rv, rc, m1, m2, t, go, w, wl};
        return v;
    endfunction

    function automatic in_t mkStim(input logic ng, input logic r1, input logic [3:0] p1,
                                   input logic r2, input logic [3:0] p2);
        in_t s;
        s = {ng, r1, p1, r2, p2};
        return s;
    endfunction

    task automatic applyStimulus(input in_t s);
        i_new_game = s.ng;
        i_p1_req   = s.r1;
        i_p1_pos   = s.p1;
        i_p2_req   = s.r2;
        i_p2_pos   = s.p2;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input out_t exp);
        out_t act;
        act = {o_p1_ack, o_p2_ack, o_rej_valid, o_rej_code, o_p1_marks, o_p2_marks,
               o_turn, o_game_over, o_winner, o_win_line};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: actual ack=%b%b rej=%b/%0d p1m=%h p2m=%h turn=%b go=%b win=%0d line=%h, expected ack=%b%b rej=%b/%0d p1m=%h p2m=%h turn=%b go=%b win=%0d line=%h",
                     name, act.ack1, act.ack2, act.rv, act.rc, act.m1, act.m2, act.turn, act.go, act.win, act.wl,
                     exp.ack1, exp.ack2, exp.rv, exp.rc, exp.m1, exp.m2, exp.turn, exp.go, exp.win, exp.wl);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        in_t  idle;
        out_t e;
        logic [8:0] m1;
        logic [8:0] m2;
        int seq[9];

        idle = '0;
        seq  = '{0, 1, 2, 4, 3, 5, 7, 6, 8};

        //                ng r1 p1    r2 p2    a1 a2 rv rc     m1       m2       t  go win   wl
        // P1 wins on the top row; requests in IDLE and DONE are ignored.
        vecs.push_back(mkVec(0, 1, 4'd0, 0, 4'd0, 0, 0, 0, 2'd0, 9'h000, 9'h000, 0, 0, 2'd0, 8'h00));
        vecs.push_back(mkVec(1, 0, 4'd0, 0, 4'd0, 0, 0, 0, 2'd0, 9'h000, 9'h000, 0, 0, 2'd0, 8'h00));
        vecs.push_back(mkVec(0, 1, 4'd0, 0, 4'd0, 1, 0, 0, 2'd0, 9'h001, 9'h000, 0, 0, 2'd0, 8'h00));
        vecs.push_back(mkVec(0, 0, 4'd0, 0, 4'd0, 0, 0, 0, 2'd0, 9'h001, 9'h000, 1, 0, 2'd0, 8'h00));
        vecs.push_back(mkVec(0, 0, 4'd0, 1, 4'd3, 0, 1, 0, 2'd0, 9'h001, 9'h008, 1, 0, 2'd0, 8'h00));
        vecs.push_back(mkVec(0, 0, 4'd0, 0, 4'd0, 0, 0, 0, 2'd0, 9'h001, 9'h008, 0, 0, 2'd0, 8'h00));
        vecs.push_back(mkVec(0, 1, 4'd1, 0, 4'd0, 1, 0, 0, 2'd0, 9'h003, 9'h008, 0, 0, 2'd0, 8'h00));
        vecs.push_back(mkVec(0, 0, 4'd0, 0, 4'd0, 0, 0, 0, 2'd0, 9'h003, 9'h008, 1, 0, 2'd0, 8'h00));
        vecs.push_back(mkVec(0, 0, 4'd0, 1, 4'd4, 0, 1, 0, 2'd0, 9'h003, 9'h018, 1, 0, 2'd0, 8'h00));
        vecs.push_back(mkVec(0, 0, 4'd0, 0, 4'd0, 0, 0, 0, 2'd0, 9'h003, 9'h018, 0, 0, 2'd0, 8'h00));
        vecs.push_back(mkVec(0, 1, 4'd2, 0, 4'd0, 1, 0, 0, 2'd0, 9'h007, 9'h018, 0, 0, 2'd0, 8'h00));
        vecs.push_back(mkVec(0, 0, 4'd0, 0, 4'd0, 0, 0, 0, 2'd0, 9'h007, 9'h018, 0, 1, 2'd1, 8'h01));
        vecs.push_back(mkVec(0, 1, 4'd6, 1, 4'd5, 0, 0, 0, 2'd0, 9'h007, 9'h018, 0, 1, 2'd1, 8'h01));
        // Occupied / out-of-range / wrong-turn rejects, with on-turn code winning.
        vecs.push_back(mkVec(1, 0, 4'd0, 0, 4'd0, 0, 0, 0, 2'd0, 9'h000, 9'h000, 0, 0, 2'd0, 8'h00));
        vecs.push_back(mkVec(0, 1, 4'd4, 0, 4'd0, 1, 0, 0, 2'd0, 9'h010, 9'h000, 0, 0, 2'd0, 8'h00));
        vecs.push_back(mkVec(0, 0, 4'd0, 0, 4'd0, 0, 0, 0, 2'd0, 9'h010, 9'h000, 1, 0, 2'd0, 8'h00));
        vecs.push_back(mkVec(0, 0, 4'd0, 1, 4'd4, 0, 0, 1, 2'd3, 9'h010, 9'h000, 1, 0, 2'd0, 8'h00));
        vecs.push_back(mkVec(0, 0, 4'd0, 1, 4'd9, 0, 0, 1, 2'd2, 9'h010, 9'h000, 1, 0, 2'd0, 8'h00));
        vecs.push_back(mkVec(0, 1, 4'd0, 1, 4'd4, 0, 0, 1, 2'd3, 9'h010, 9'h000, 1, 0, 2'd0, 8'h00));
        vecs.push_back(mkVec(0, 1, 4'd0, 0, 4'd0, 0, 0, 1, 2'd1, 9'h010, 9'h000, 1, 0, 2'd0, 8'h00));
        vecs.push_back(mkVec(0, 0, 4'd0, 0, 4'd0, 0, 0, 0, 2'd0, 9'h010, 9'h000, 1, 0, 2'd0, 8'h00));
        // new_game beats a legal same-cycle move; simultaneous requests; held request after ack.
        vecs.push_back(mkVec(1, 0, 4'd0, 1, 4'd5, 0, 0, 0, 2'd0, 9'h000, 9'h000, 0, 0, 2'd0, 8'h00));
        vecs.push_back(mkVec(0, 1, 4'd0, 1, 4'd8, 1, 0, 1, 2'd1, 9'h001, 9'h000, 0, 0, 2'd0, 8'h00));
        vecs.push_back(mkVec(0, 1, 4'd0, 0, 4'd0, 0, 0, 0, 2'd0, 9'h001, 9'h000, 1, 0, 2'd0, 8'h00));
        vecs.push_back(mkVec(0, 1, 4'd0, 0, 4'd0, 0, 0, 1, 2'd1, 9'h001, 9'h000, 1, 0, 2'd0, 8'h00));
        vecs.push_back(mkVec(0, 0, 4'd0, 0, 4'd0, 0, 0, 0, 2'd0, 9'h001, 9'h000, 1, 0, 2'd0, 8'h00));

        reset      = 1'b1;
        i_new_game = 1'b0;
        i_p1_req   = 1'b0;
        i_p1_pos   = 4'd0;
        i_p2_req   = 1'b0;
        i_p2_pos   = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_state", '0);
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].stim);
            checkOutput($sformatf("vec%0d", i), vecs[i].exp);
        end

        // Full-board draw, then requests while DONE.
        applyStimulus(mkStim(1, 0, 4'd0, 0, 4'd0));
        checkOutput("draw_newgame", '0);
        m1 = '0;
        m2 = '0;
        for (int i = 0; i < 9; i++) begin
            e = '0;
            if (i % 2 == 0) begin
                applyStimulus(mkStim(0, 1, 4'(seq[i]), 0, 4'd0));
                m1 = m1 | (9'd1 << seq[i]);
                e.ack1 = 1'b1;
            end else begin
                applyStimulus(mkStim(0, 0, 4'd0, 1, 4'(seq[i])));
                m2 = m2 | (9'd1 << seq[i]);
                e.ack2 = 1'b1;
                e.turn = 1'b1;
            end
            e.m1 = m1;
            e.m2 = m2;
            checkOutput($sformatf("draw_move%0d", i), e);
            applyStimulus(idle);
            e.ack1 = 1'b0;
            e.ack2 = 1'b0;
            if (i < 8) begin
                e.turn = (i % 2 == 0);
            end else begin
                e.go  = 1'b1;
                e.win = 2'd3;
            end
            checkOutput($sformatf("draw_check%0d", i), e);
        end
        applyStimulus(mkStim(0, 1, 4'd0, 1, 4'd1));
        e.ack1 = 1'b0;
        e.ack2 = 1'b0;
        checkOutput("done_ignores_req", e);

        // Asynchronous reset in the middle of a game.
        applyStimulus(mkStim(1, 0, 4'd0, 0, 4'd0));
        applyStimulus(mkStim(0, 1, 4'd0, 0, 4'd0));
        applyStimulus(idle);
        applyStimulus(mkStim(0, 0, 4'd0, 1, 4'd1));
        applyStimulus(idle);
        applyStimulus(mkStim(0, 1, 4'd2, 0, 4'd0));
        applyStimulus(idle);
        e = '0;
        e.m1   = 9'h005;
        e.m2   = 9'h002;
        e.turn = 1'b1;
        checkOutput("pre_reset_board", e);
        #3;
        reset = 1'b1;
        #1;
        checkOutput("async_reset", '0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        applyStimulus(mkStim(0, 1, 4'd0, 0, 4'd0));
        checkOutput("idle_after_reset", '0);
        applyStimulus(mkStim(1, 0, 4'd0, 0, 4'd0));
        checkOutput("newgame_after_reset", '0);
        applyStimulus(mkStim(0, 1, 4'd4, 0, 4'd0));
        e = '0;
        e.ack1 = 1'b1;
        e.m1   = 9'h010;
        checkOutput("move_after_reset", e);

`ifdef TTT_TURN_TIMEOUT_EN
        // Twenty idle WAIT_MOVE cycles forfeit the game to P2.
        applyStimulus(mkStim(1, 0, 4'd0, 0, 4'd0));
        checkOutput("timeout_newgame", '0);
        repeat (19) applyStimulus(idle);
        checkOutput("timeout_not_yet", '0);
        applyStimulus(idle);
        e = '0;
        e.go  = 1'b1;
        e.win = 2'd2;
        checkOutput("timeout_result", e);
        checks++;
        if (o_timeout !== 1'b1) begin
            errors++;
            $display("[TB] FAIL timeout_flag: actual %b, expected 1", o_timeout);
        end
        applyStimulus(mkStim(1, 0, 4'd0, 0, 4'd0));
        checks++;
        if (o_timeout !== 1'b0) begin
            errors++;
            $display("[TB] FAIL timeout_clear: actual %b, expected 0", o_timeout);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ttt_game_ctrl.md
Name: ttt_game_ctrl

Overview:
- Turn sequencer and move arbiter for the tic-tac-toe board datapath.
- Accepts move requests from two player input ports and grants only the player whose turn it is.
- Rejects illegal moves, owns the board state, and detects win or draw.
- Drives the board-display and winner-display logic downstream.

Parameters:
- N_CELLS, 9, number of board cells; fixed 3x3 geometry, only 9 supported.
- TIMEOUT_CYCLES, 1000, turn time limit in clk cycles; used only with the optional feature.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset; clock is clk
- new_game  in  1  one-cycle pulse; clears board and starts a game with P1 to move
- p1_req  in  1  player 1 move request, level, sampled each cycle
- p1_pos  in  4  player 1 cell index, 0..8
- p2_req  in  1  player 2 move request
- p2_pos  in  4  player 2 cell index, 0..8
- p1_ack  out  1  one-cycle pulse: P1 move accepted
- p2_ack  out  1  one-cycle pulse: P2 move accepted
- rej_valid  out  1  one-cycle pulse: a request was rejected
- rej_code  out  2  rejection reason: 1 wrong turn, 2 out of range, 3 occupied
- p1_marks  out  9  cells owned by P1
- p2_marks  out  9  cells owned by P2
- turn  out  1  player to move: 0 = P1, 1 = P2
- game_over  out  1  high in DONE
- winner  out  2  0 none, 1 P1, 2 P2, 3 draw
- win_line  out  8  one-hot winning line: rows 0-2, cols 3-5, diag 0/4/8 = 6, diag 2/4/6 = 7

Behaviour:
- Reset: state IDLE. All outputs 0: marks, turn, acks, rej_valid, rej_code, game_over, winner, win_line.
- IDLE:
  - new_game -> WAIT_MOVE with marks cleared and turn = 0.
  - Requests are ignored; no ack, no reject.
- WAIT_MOVE: the requester matching turn is the candidate.
  - Legal move (pos <= 8, cell not in p1_marks|p2_marks): register is updated at the clock edge; ack pulses in the following cycle; -> CHECK.
  - Candidate illegal: rej_valid and rej_code pulse next cycle; stay in WAIT_MOVE; turn unchanged.
  - Out-of-range check takes priority over the occupied check.
  - Off-turn requester asserting req: rejected with code 1, whether or not the on-turn player also requests.
  - Both rejected in the same cycle: a single rej_valid pulse; code of the on-turn requester wins.
- Request level semantics: a held req after an ack is re-evaluated after CHECK.
  - By then the cell is occupied, or it is the other player's turn, so a held req yields a reject.
  - Requesters must drop req after ack.
- CHECK: one cycle; evaluates the 8 lines for the player who just moved.
  - Line complete: winner = 1 or 2, win_line set -> DONE.
  - Else all 9 cells occupied: winner = 3, win_line = 0 -> DONE.
  - Else: turn toggles -> WAIT_MOVE.
  - Multiple lines complete at once: all corresponding win_line bits are set.
- DONE:
  - game_over = 1; board, winner and win_line hold.
  - Requests are ignored (no reject).
  - new_game -> WAIT_MOVE with board, winner and win_line cleared, turn = 0.
- new_game in WAIT_MOVE or CHECK: aborts the current game and restarts identically to the IDLE case. new_game takes priority over any same-cycle move.
- Reset mid-game: board is cleared asynchronously; return to IDLE.
- Move-to-ack latency is 1 cycle; move-to-winner latency is 2 cycles.

Optional Feature:
- Macro: TTT_TURN_TIMEOUT_EN.
- Defined:
  - A turn counter clears on entry to WAIT_MOVE and increments each WAIT_MOVE cycle.
  - Rejected moves do not clear it.
  - On reaching TIMEOUT_CYCLES, -> DONE with winner = opponent of turn and win_line = 0.
  - An extra output timeout (1 bit) is set with this result and cleared by new_game or reset.
- Undefined: no counter and no timeout port; WAIT_MOVE waits indefinitely.

Decomposition:
- ttt_pkg:
  - state_e {IDLE, WAIT_MOVE, CHECK, DONE}
  - rej_e codes
  - winner_e codes
  - localparam WIN_LINES: 8 x 9-bit cell masks
- Sub-module ttt_line_check:
  - Combinational; input 9-bit marks; output 8-bit line-complete vector via mask compare.
  - Instantiated once, fed the mover's marks.

Test Plan:
- Reset, new_game; P1 plays 0,1,2 and P2 plays 3,4 alternately -> p1_ack/p2_ack each 1 cycle after req. Winner = 1 and win_line = 8'b0000_0001 two cycles after the P1 move at cell 2; game_over = 1.
- P1 plays 4, then P2 requests 4 -> rej_code 3; turn stays 1; p2_marks unchanged. Then P2 requests pos 9 -> rej_code 2.
- In WAIT_MOVE with turn = 0, P1 requests 0 and P2 requests 8 in the same cycle -> p1_ack only, rej_code 1. p2_marks = 0.
- Play the sequence 0,1,2,4,3,5,7,6,8 (no line) -> winner = 3 after the 9th move; requests in DONE produce no ack or reject.
- Assert reset mid-game after 3 moves -> all marks 0 and IDLE immediately, without waiting for a clk edge. Then new_game -> turn = 0.
- With TTT_TURN_TIMEOUT_EN and TIMEOUT_CYCLES = 20: after new_game, no requests for 20 cycles -> winner = 2, timeout = 1, game_over = 1.
